// File: rtl/sensor_poll_controller.sv
// Polls a single-wire humidity/temperature decoder for two requesters.
// Requests are served round-robin, starts are spaced by MIN_GAP cycles, and failed attempts are retried.
// Ports: clock/reset; req/grant/done/ok/fail_code to the requesters; hum_*/temp_* hold the last good
//        frame; busy; dec_* drive and observe the decoder.
module sensor_poll_controller #(
  parameter int MIN_GAP       = 100_000_000,
  parameter int TXN_TIMEOUT   = 10_000_000,
  parameter int START_TIMEOUT = 1_000,
  parameter int MAX_RETRY     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       ok,
  output logic [1:0] fail_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_float,
  output logic [7:0] temp_int,
  output logic [7:0] temp_float,
  output logic       busy,
  output logic       dec_enable,
  output logic       dec_reset,
  input  logic       dec_hold,
  input  logic       dec_error,
  input  logic [7:0] dec_hum_int,
  input  logic [7:0] dec_hum_float,
  input  logic [7:0] dec_temp_int,
  input  logic [7:0] dec_temp_float,
  input  logic [7:0] dec_checksum
);

  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int TW = $clog2(TXN_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_GAP);
  // The start decision is taken in GAP_WAIT, START follows one cycle later, and the
  // counter restarts the cycle after START; leaving two counts early places successive
  // start pulses exactly MIN_GAP cycles apart. Assumes MIN_GAP >= 2.
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 2);
  // The attempt timer reads 0 in the cycle after START, so it lags elapsed cycles by one.
  localparam logic [TW-1:0] TMR_MAX    = TW'(TXN_TIMEOUT);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] TXN_LAST   = TW'(TXN_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_NORESP  = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_BAD     = 2'd3;

  typedef enum logic [2:0] {
    IDLE, GAP_WAIT, START, WAIT_BUSY, WAIT_DONE, CHECK, RESPOND
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   attempt_tmr;
  logic [RW-1:0]   retry_cnt;
  logic            rr_prio;        // requester that wins a tie
  logic            fail_now;
  logic [1:0]      fail_cause;
  logic            retry_left;
  logic [1:0]      winner;

  logic            fr_err;
  logic [7:0]      fr_hi, fr_hf, fr_ti, fr_tf, fr_ck;
  logic [9:0]      fr_sum;
  logic            frame_good;

  assign fr_sum = {2'b00, fr_hi} + {2'b00, fr_hf} + {2'b00, fr_ti} + {2'b00, fr_tf};
  assign frame_good = !fr_err
                    && ((fr_sum & 10'h0FF) == {2'b00, fr_ck})
                    && (|{fr_hi, fr_hf, fr_ti, fr_tf, fr_ck});

  assign retry_left = (retry_cnt < RETRY_MAX);

  always_comb begin
    winner = 2'b00;
    if (req == 2'b11) winner = rr_prio ? 2'b10 : 2'b01;
    else              winner = req;
  end

  always_comb begin
    state_nxt  = state;
    fail_now   = 1'b0;
    fail_cause = FC_NONE;
    case (state)
      IDLE:      if (|req) state_nxt = GAP_WAIT;
      GAP_WAIT:  if (gap_cnt >= GAP_LAST) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (dec_hold) state_nxt = WAIT_DONE;
        else if (attempt_tmr >= START_LAST) begin
          fail_now   = 1'b1;
          fail_cause = FC_NORESP;
        end
      end
      WAIT_DONE: begin
        if (!dec_hold) state_nxt = CHECK;
        else if (attempt_tmr >= TXN_LAST) begin
          fail_now   = 1'b1;
          fail_cause = FC_TIMEOUT;
        end
      end
      CHECK: begin
        if (frame_good) state_nxt = RESPOND;
        else begin
          fail_now   = 1'b1;
          fail_cause = FC_BAD;
        end
      end
      RESPOND:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (fail_now) state_nxt = retry_left ? GAP_WAIT : RESPOND;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= GAP_MAX;
      attempt_tmr <= '0;
      retry_cnt   <= '0;
      rr_prio     <= 1'b0;
      grant       <= 2'b00;
      ok          <= 1'b0;
      fail_code   <= FC_NONE;
      hum_int     <= '0;
      hum_float   <= '0;
      temp_int    <= '0;
      temp_float  <= '0;
      fr_err      <= 1'b0;
      fr_hi       <= '0;
      fr_hf       <= '0;
      fr_ti       <= '0;
      fr_tf       <= '0;
      fr_ck       <= '0;
    end else begin
      state <= state_nxt;

      if (state == START)        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GW'(1);

      if (state == START)            attempt_tmr <= '0;
      else if (attempt_tmr != TMR_MAX) attempt_tmr <= attempt_tmr + TW'(1);

      if (state == IDLE && (|req)) begin
        grant   <= winner;
        rr_prio <= ~winner[1];
      end

      if (state == WAIT_DONE && !dec_hold) begin
        fr_err <= dec_error;
        fr_hi  <= dec_hum_int;
        fr_hf  <= dec_hum_float;
        fr_ti  <= dec_temp_int;
        fr_tf  <= dec_temp_float;
        fr_ck  <= dec_checksum;
      end

      if (state == CHECK && frame_good) begin
        hum_int    <= fr_hi;
        hum_float  <= fr_hf;
        temp_int   <= fr_ti;
        temp_float <= fr_tf;
        ok         <= 1'b1;
        fail_code  <= FC_NONE;
      end

      if (fail_now) begin
        if (retry_left) retry_cnt <= retry_cnt + RW'(1);
        else begin
          ok        <= 1'b0;
          fail_code <= fail_cause;
        end
      end

      if (state == RESPOND) begin
        grant     <= 2'b00;
        retry_cnt <= '0;
      end
    end
  end

  assign done       = (state == RESPOND) ? grant : 2'b00;
  assign busy       = (state != IDLE);
  assign dec_enable = (state != IDLE);
  assign dec_reset  = (state == START);

endmodule

// File: tb/tb_sensor_poll_controller.sv
// Bench for sensor_poll_controller: a behavioural decoder answers each start pulse,
// stimulus pushes expected responses, and a monitor pops and compares on every done.
module tb_sensor_poll_controller;

  localparam int MIN_GAP       = 100;
  localparam int TXN_TIMEOUT   = 500;
  localparam int START_TIMEOUT = 20;
  localparam int MAX_RETRY     = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] grant, done, fail_code;
  logic       ok, busy, dec_enable, dec_reset;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic       dec_hold = 1'b0, dec_error = 1'b0;
  logic [7:0] dec_hum_int = 8'h00, dec_hum_float = 8'h00, dec_temp_int = 8'h00;
  logic [7:0] dec_temp_float = 8'h00, dec_checksum = 8'h00;

  sensor_poll_controller #(
    .MIN_GAP(MIN_GAP), .TXN_TIMEOUT(TXN_TIMEOUT),
    .START_TIMEOUT(START_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .grant(grant), .done(done), .ok(ok),
    .fail_code(fail_code), .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int),
    .temp_float(temp_float), .busy(busy), .dec_enable(dec_enable), .dec_reset(dec_reset),
    .dec_hold(dec_hold), .dec_error(dec_error), .dec_hum_int(dec_hum_int),
    .dec_hum_float(dec_hum_float), .dec_temp_int(dec_temp_int),
    .dec_temp_float(dec_temp_float), .dec_checksum(dec_checksum)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] done; logic ok; logic [1:0] fc;
    logic [7:0] hi; logic [7:0] hf; logic [7:0] ti; logic [7:0] tf;
  } resp_t;
  typedef struct packed {
    logic err; logic [7:0] hi; logic [7:0] hf; logic [7:0] ti; logic [7:0] tf; logic [7:0] ck;
  } frame_t;
  typedef enum int { M_NONE, M_FRAME, M_NORESP, M_STUCK } mode_t;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     busy_rise_cyc = 0;
  int     start_q[$];
  resp_t  exp_q[$];
  frame_t frame_q[$];
  mode_t  mode = M_NONE;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Decoder model: reacts to each start pulse according to the current mode.
  initial begin : decoder
    frame_t fr;
    fr = '0;
    forever begin
      @(posedge clock); #1;
      if (mode != M_STUCK) dec_hold = 1'b0;
      if (dec_reset && !reset) begin
        case (mode)
          M_FRAME: begin
            if (frame_q.size() > 0) fr = frame_q.pop_front();
            repeat (3) begin @(posedge clock); #1; end
            dec_hold = 1'b1;
            repeat (8) begin @(posedge clock); #1; end
            dec_error      = fr.err;
            dec_hum_int    = fr.hi;
            dec_hum_float  = fr.hf;
            dec_temp_int   = fr.ti;
            dec_temp_float = fr.tf;
            dec_checksum   = fr.ck;
            dec_hold       = 1'b0;
          end
          M_STUCK: dec_hold = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Monitor: records start pulses and scoreboards every done pulse.
  initial begin : monitor
    logic [1:0] prev_done;
    logic       prev_busy, prev_rst;
    resp_t      e;
    prev_done = 2'b00; prev_busy = 1'b0; prev_rst = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        prev_done = 2'b00; prev_busy = 1'b0; prev_rst = 1'b0;
      end else begin
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (dec_reset) start_q.push_back(cyc);
        if (prev_rst) check("dec_reset_one_cycle", {31'd0, dec_reset}, 32'd0);
        if (prev_done != 2'b00) check("done_one_cycle", {30'd0, done}, 32'd0);
        if (done != 2'b00) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=%b, required no done", done);
          end else begin
            e = exp_q.pop_front();
            check("done_vector", {30'd0, done}, {30'd0, e.done});
            check("ok", {31'd0, ok}, {31'd0, e.ok});
            check("fail_code", {30'd0, fail_code}, {30'd0, e.fc});
            check("measurement", {hum_int, hum_float, temp_int, temp_float},
                  {e.hi, e.hf, e.ti, e.tf});
          end
        end
        prev_done = done; prev_busy = busy; prev_rst = dec_reset;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin @(posedge clock); #2; end
    reset = 1'b0;
    start_q.delete();
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin @(posedge clock); #2; n++; end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s_wait: dones %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic check_starts(input string name, input int n, input int spacing);
    check({name, "_starts"}, start_q.size(), n);
    if (start_q.size() == n)
      for (int i = 1; i < n; i++)
        check({name, "_spacing"}, start_q[i] - start_q[i-1], spacing);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_grant_done"}, {28'd0, grant, done}, 32'd0);
    check({name, "_ok_fc"}, {29'd0, ok, fail_code}, 32'd0);
    check({name, "_busy_en_rst"}, {29'd0, busy, dec_enable, dec_reset}, 32'd0);
    check({name, "_meas"}, {hum_int, hum_float, temp_int, temp_float}, 32'd0);
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    do_reset();
    check_idle_outputs("reset");

    // Single good frame from requester 0.
    mode = M_FRAME;
    frame_q.push_back('{1'b0, 8'h37, 8'h00, 8'h19, 8'h00, 8'h50});
    exp_q.push_back('{2'b01, 1'b1, 2'd0, 8'h37, 8'h00, 8'h19, 8'h00});
    req = 2'b01;
    wait_dones(1, 200, "good");
    req = 2'b00;
    check_starts("good", 1, 0);
    if (start_q.size() == 1) check("start_after_gap_entry", start_q[0] - busy_rise_cyc, 1);

    // Both requesting from reset: requester 0 first, then requester 1.
    do_reset();
    done_cnt = 0;
    frame_q.push_back('{1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    frame_q.push_back('{1'b0, 8'h40, 8'h05, 8'h1A, 8'h03, 8'h62});
    exp_q.push_back('{2'b01, 1'b1, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44});
    exp_q.push_back('{2'b10, 1'b1, 2'd0, 8'h40, 8'h05, 8'h1A, 8'h03});
    req = 2'b11;
    wait_dones(1, 300, "rr_first");
    req = 2'b10;
    wait_dones(2, 300, "rr_second");
    req = 2'b00;
    check_starts("rr", 2, MIN_GAP);

    // Bad checksum three times: bad-frame failure, measurements keep previous frame.
    start_q.delete();
    repeat (3) frame_q.push_back('{1'b0, 8'h37, 8'h00, 8'h19, 8'h00, 8'h51});
    exp_q.push_back('{2'b01, 1'b0, 2'd3, 8'h40, 8'h05, 8'h1A, 8'h03});
    req = 2'b01;
    wait_dones(3, 600, "badframe");
    req = 2'b00;
    check_starts("badframe", 3, MIN_GAP);
    repeat (5) begin @(posedge clock); #2; end
    check("result_hold", {29'd0, ok, fail_code}, {29'd0, 1'b0, 2'd3});

    // No response; requester drops req after the first start and still gets done.
    start_q.delete();
    mode = M_NORESP;
    exp_q.push_back('{2'b10, 1'b0, 2'd1, 8'h40, 8'h05, 8'h1A, 8'h03});
    req = 2'b10;
    n = 0;
    while (start_q.size() == 0 && n < 50) begin @(posedge clock); #2; n++; end
    req = 2'b00;
    wait_dones(4, 600, "noresp");
    check_starts("noresp", 3, MIN_GAP);
    if (start_q.size() == 3)
      check("noresp_done_delay", done_cyc - start_q[2], START_TIMEOUT + 1);

    // Decoder stuck busy: timeout after TXN_TIMEOUT cycles per attempt.
    start_q.delete();
    mode = M_STUCK;
    exp_q.push_back('{2'b01, 1'b0, 2'd2, 8'h40, 8'h05, 8'h1A, 8'h03});
    req = 2'b01;
    wait_dones(5, 2000, "timeout");
    req = 2'b00;
    check_starts("timeout", 3, TXN_TIMEOUT + 2);
    if (start_q.size() == 3)
      check("timeout_done_delay", done_cyc - start_q[2], TXN_TIMEOUT + 1);

    // Reset in the middle of WAIT_DONE: everything clears and no done follows.
    mode = M_NONE;
    repeat (3) begin @(posedge clock); #2; end
    start_q.delete();
    mode = M_STUCK;
    req = 2'b01;
    n = 0;
    while (start_q.size() == 0 && n < 50) begin @(posedge clock); #2; n++; end
    check("midreset_started", start_q.size(), 1);
    repeat (30) begin @(posedge clock); #2; end
    req = 2'b00;
    reset = 1'b1;
    @(posedge clock); #2;
    check_idle_outputs("midreset");
    mode = M_NONE;
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (40) begin @(posedge clock); #2; end
    check("midreset_no_done", done_cnt, 5);
    check("midreset_idle", {30'd0, busy, dec_enable}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
